// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//
// Purpose:
//    Shares one UART transmitter between two requesters. Each requester sends a
//    1- or 2-byte message. When the scheduler is idle it picks a requester with
//    round-robin arbitration. It then latches that requester's payload, length
//    and parity configuration, and sends the bytes low byte first. Each byte
//    uses the transmitter's DATA_VALID / BUSY handshake. The scheduler pulses
//    MSG_DONE after the last byte's frame has finished.
//
// Optional feature (macro UART_SCHED_TIMEOUT_EN):
//    When defined, a TO_W-bit counter watches WAIT_HI. If TX_BUSY has not risen
//    after TIMEOUT cycles, the message is dropped, TIMEOUT_ERR pulses and the
//    scheduler returns to IDLE. When undefined, no counter is built, WAIT_HI
//    waits forever and o_timeout_err is tied low.
//
// Parameters:
//    TIMEOUT  cycles to wait for TX_BUSY to rise after a strobe (timeout build)
//    TO_W     width of the timeout counter; TIMEOUT must be < 2**TO_W
//
// Ports:
//    i_clk, i_rst              clock, synchronous active-high reset
//    i_req0/1                  message request, held until the matching ACK
//    i_len0/1                  0 = 1 byte, 1 = 2 bytes
//    i_data0/1 [15:0]          payload, byte0 = [7:0], byte1 = [15:8]
//    o_ack0/1                  one-cycle grant pulse (payload captured here)
//    i_cfg_par_en/typ          parity config, sampled at grant
//    o_tx_p_data [7:0]         byte to the transmitter (holds between strobes)
//    o_tx_data_valid           one-cycle byte strobe
//    o_tx_par_en/typ           latched parity config for the whole message
//    i_tx_busy                 transmitter busy flag
//    o_sched_busy              high in every state except IDLE
//    o_msg_done                one-cycle pulse after the last frame ends
//    o_msg_src                 requester of the current or most recent message
//    o_timeout_err             one-cycle pulse when a message is aborted
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
   parameter int TIMEOUT = 31,
   parameter int TO_W    = 5
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req0,
   input  logic        i_req1,
   input  logic        i_len0,
   input  logic        i_len1,
   input  logic [15:0] i_data0,
   input  logic [15:0] i_data1,
   output logic        o_ack0,
   output logic        o_ack1,
   input  logic        i_cfg_par_en,
   input  logic        i_cfg_par_typ,
   output logic [7:0]  o_tx_p_data,
   output logic        o_tx_data_valid,
   output logic        o_tx_par_en,
   output logic        o_tx_par_typ,
   input  logic        i_tx_busy,
   output logic        o_sched_busy,
   output logic        o_msg_done,
   output logic        o_msg_src,
   output logic        o_timeout_err
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_WAIT_HI = 2'd2,
      S_WAIT_LO = 2'd3
   } state_t;

   state_t      r_state;
   logic        r_last;    // requester granted most recently; 1 after reset so 0 wins first tie
   logic        r_idx;     // byte index within the message
   logic        r_len;     // latched length (index of the last byte)
   logic [15:0] r_data;    // latched payload

   logic        w_any_req;
   logic        w_gnt;
   logic [7:0]  w_byte;

   // On a tie, grant the requester that was not granted last time.
   // Otherwise grant whichever requester is asserting.
   assign w_any_req = i_req0 | i_req1;
   assign w_gnt     = (i_req0 & i_req1) ? ~r_last : i_req1;
   assign w_byte    = r_idx ? r_data[15:8] : r_data[7:0];

   // This block builds no hardware. It is a visible marker in the hierarchy
   // when TIMEOUT cannot be represented in the TO_W-bit counter.
   if ((TIMEOUT < 1) || (TIMEOUT >= (2 ** TO_W))) begin : g_timeout_cfg_invalid
   end

`ifdef UART_SCHED_TIMEOUT_EN
   logic [TO_W-1:0] r_to_cnt;
`else
   assign o_timeout_err = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state         <= S_IDLE;
         r_last          <= 1'b1;
         r_idx           <= 1'b0;
         r_len           <= 1'b0;
         r_data          <= '0;
         o_ack0          <= 1'b0;
         o_ack1          <= 1'b0;
         o_tx_p_data     <= '0;
         o_tx_data_valid <= 1'b0;
         o_tx_par_en     <= 1'b0;
         o_tx_par_typ    <= 1'b0;
         o_sched_busy    <= 1'b0;
         o_msg_done      <= 1'b0;
         o_msg_src       <= 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
         r_to_cnt        <= '0;
         o_timeout_err   <= 1'b0;
`endif
      end else begin
         // The pulse outputs default low. Each state raises its pulse for one cycle.
         o_ack0          <= 1'b0;
         o_ack1          <= 1'b0;
         o_tx_data_valid <= 1'b0;
         o_msg_done      <= 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
         o_timeout_err   <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  o_ack0       <= ~w_gnt;
                  o_ack1       <= w_gnt;
                  r_data       <= w_gnt ? i_data1 : i_data0;
                  r_len        <= w_gnt ? i_len1 : i_len0;
                  o_tx_par_en  <= i_cfg_par_en;
                  o_tx_par_typ <= i_cfg_par_typ;
                  r_idx        <= 1'b0;
                  r_last       <= w_gnt;
                  o_msg_src    <= w_gnt;
                  o_sched_busy <= 1'b1;
                  r_state      <= S_ISSUE;
               end
            end

            S_ISSUE: begin
               // Wait here until the transmitter has finished the previous frame.
               if (!i_tx_busy) begin
                  o_tx_p_data     <= w_byte;
                  o_tx_data_valid <= 1'b1;
                  r_state         <= S_WAIT_HI;
`ifdef UART_SCHED_TIMEOUT_EN
                  r_to_cnt        <= '0;
`endif
               end
            end

            S_WAIT_HI: begin
               if (i_tx_busy) begin
                  r_state <= S_WAIT_LO;
`ifdef UART_SCHED_TIMEOUT_EN
               end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
                  // This edge is the TIMEOUT-th cycle spent in WAIT_HI.
                  // Abort the message: no further bytes and no MSG_DONE.
                  o_timeout_err <= 1'b1;
                  o_sched_busy  <= 1'b0;
                  r_state       <= S_IDLE;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
`endif
               end
            end

            S_WAIT_LO: begin
               if (!i_tx_busy) begin
                  if (r_idx == r_len) begin
                     o_msg_done   <= 1'b1;
                     o_sched_busy <= 1'b0;
                     r_state      <= S_IDLE;
                  end else begin
                     r_idx   <= 1'b1;
                     r_state <= S_ISSUE;
                  end
               end
            end

            default: begin
               o_sched_busy <= 1'b0;
               r_state      <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
//
// Bench for uart_tx_scheduler. A small transmitter model raises TX_BUSY one
// cycle after each strobe and holds it for bm_len cycles. Message rows come
// from a table. Expected bytes and sources go into queues when a message is
// driven. A negedge monitor pops those queues on each strobe and MSG_DONE.
// Hand-written sequences cover reset mid-message and the handshake timeout.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_req0 = 1'b0, i_req1 = 1'b0;
   logic        i_len0 = 1'b0, i_len1 = 1'b0;
   logic [15:0] i_data0 = '0, i_data1 = '0;
   logic        i_cfg_par_en = 1'b0, i_cfg_par_typ = 1'b0;
   logic        i_tx_busy = 1'b0;
   logic        o_ack0, o_ack1, o_tx_data_valid, o_tx_par_en, o_tx_par_typ;
   logic [7:0]  o_tx_p_data;
   logic        o_sched_busy, o_msg_done, o_msg_src, o_timeout_err;

   uart_tx_scheduler #(.TIMEOUT(31), .TO_W(5)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_req0(i_req0), .i_req1(i_req1),
      .i_len0(i_len0), .i_len1(i_len1),
      .i_data0(i_data0), .i_data1(i_data1),
      .o_ack0(o_ack0), .o_ack1(o_ack1),
      .i_cfg_par_en(i_cfg_par_en), .i_cfg_par_typ(i_cfg_par_typ),
      .o_tx_p_data(o_tx_p_data), .o_tx_data_valid(o_tx_data_valid),
      .o_tx_par_en(o_tx_par_en), .o_tx_par_typ(o_tx_par_typ),
      .i_tx_busy(i_tx_busy),
      .o_sched_busy(o_sched_busy), .o_msg_done(o_msg_done),
      .o_msg_src(o_msg_src), .o_timeout_err(o_timeout_err)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [1:0]  mask;   // {req1, req0}
      logic        len0;
      logic        len1;
      logic [15:0] d0;
      logic [15:0] d1;
      logic        pe;
      logic        pt;
      logic        src;    // expected winner
   } vec_t;

   typedef struct {
      logic [7:0] b;
      bit         second;
   } sb_t;

   sb_t  byte_q[$];
   logic src_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transmitter model: busy rises one cycle after the strobe and lasts bm_len cycles.
   int bcnt = 0;
   bit pend = 0;
   bit bm_en = 1;
   int bm_len = 10;
   always @(posedge i_clk) begin
      #1;
      if (pend) begin
         bcnt = bm_len;
         pend = 0;
      end else if (bcnt > 0) begin
         bcnt--;
      end
      if (o_tx_data_valid && bm_en) pend = 1;
      i_tx_busy = (bcnt != 0);
   end

   // Monitor: scoreboard pops, the inter-byte gap, and the ACK/strobe exclusion.
   bit   prev_busy = 0;
   bit   gap_arm = 0;
   int   gap_cnt = 0;
   sb_t  mon_e;
   logic mon_src;
   always @(negedge i_clk) begin
      if (prev_busy && !i_tx_busy) begin
         gap_arm = 1;
         gap_cnt = 0;
      end else if (gap_arm) begin
         gap_cnt++;
      end
      prev_busy = i_tx_busy;
      chk("ack_strobe_overlap", (o_ack0 | o_ack1) & o_tx_data_valid, 0);
      if (o_tx_data_valid) begin
         chk("strobe_expected", byte_q.size() != 0, 1);
         if (byte_q.size() != 0) begin
            mon_e = byte_q.pop_front();
            chk("tx_byte", o_tx_p_data, mon_e.b);
            if (mon_e.second) chk("byte_gap", gap_cnt, 2);
         end
         gap_arm = 0;
      end
      if (o_msg_done) begin
         chk("done_expected", src_q.size() != 0, 1);
         if (src_q.size() != 0) begin
            mon_src = src_q.pop_front();
            chk("msg_src", o_msg_src, mon_src);
         end
         gap_arm = 0;
      end
   end

   task automatic wait_ack(output int n);
      n = 0;
      do begin
         @(negedge i_clk);
         n++;
      end while (!(o_ack0 || o_ack1) && n < 50);
      chk("ack_seen", n < 50, 1);
   endtask

   task automatic run_msg(input vec_t v);
      logic [15:0] d;
      logic        l;
      int          n;
      bit          par_ok;
      d = v.src ? v.d1 : v.d0;
      l = v.src ? v.len1 : v.len0;
      byte_q.push_back('{d[7:0], 1'b0});
      if (l) byte_q.push_back('{d[15:8], 1'b1});
      src_q.push_back(v.src);
      i_len0 = v.len0;  i_len1 = v.len1;
      i_data0 = v.d0;   i_data1 = v.d1;
      i_cfg_par_en = v.pe;
      i_cfg_par_typ = v.pt;
      i_req0 = v.mask[0];
      i_req1 = v.mask[1];
      wait_ack(n);
      chk("ack_onehot", o_ack0 ^ o_ack1, 1);
      chk("ack_src", o_ack1, v.src);
      chk("par_latched", {o_tx_par_en, o_tx_par_typ}, {v.pe, v.pt});
      if (o_ack0) i_req0 = 1'b0;
      if (o_ack1) i_req1 = 1'b0;
      @(negedge i_clk);
      chk("first_strobe_latency", o_tx_data_valid, 1);
      // Toggle the parity config and the losing requester's payload mid-message.
      par_ok = 1;
      n = 0;
      while (!o_msg_done && n < 300) begin
         if (o_tx_par_en !== v.pe || o_tx_par_typ !== v.pt) par_ok = 0;
         i_cfg_par_typ = ~i_cfg_par_typ;
         i_cfg_par_en  = ~i_cfg_par_en;
         if (v.src) i_data0 = ~i_data0;
         else       i_data1 = ~i_data1;
         @(negedge i_clk);
         n++;
      end
      chk("done_seen", n < 300, 1);
      chk("par_stable", par_ok, 1);
      chk("par_typ_at_done", o_tx_par_typ, v.pt);
      chk("bytes_sent", byte_q.size(), 0);
      chk("idle_after_done", o_sched_busy, 0);
   endtask

   vec_t vecs[5];

   initial begin
      int n;
      int n_ev;
      vecs[0] = '{2'b01, 1'b0, 1'b0, 16'h00A5, 16'h0000, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{2'b10, 1'b0, 1'b1, 16'h0000, 16'h3C81, 1'b0, 1'b1, 1'b1};
      vecs[2] = '{2'b11, 1'b1, 1'b0, 16'h1122, 16'h0044, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{2'b11, 1'b0, 1'b1, 16'h0055, 16'h6677, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{2'b11, 1'b0, 1'b0, 16'h00F0, 16'h0099, 1'b1, 1'b0, 1'b0};

      // Reset state.
      i_rst = 1'b1;
      repeat (2) @(negedge i_clk);
      chk("reset_outputs", {o_ack0, o_ack1, o_tx_p_data, o_tx_data_valid, o_tx_par_en,
                            o_tx_par_typ, o_sched_busy, o_msg_done, o_msg_src, o_timeout_err}, 0);
      i_rst = 1'b0;

      for (int i = 0; i < 5; i++) run_msg(vecs[i]);
      i_req0 = 1'b0;
      i_req1 = 1'b0;

      // Reset in WAIT_LO of byte 0 of a 2-byte message.
      byte_q.push_back('{8'hEF, 1'b0});
      i_len0 = 1'b1; i_data0 = 16'hBEEF; i_cfg_par_en = 1'b1; i_cfg_par_typ = 1'b1;
      i_req0 = 1'b1;
      wait_ack(n);
      chk("rst_msg_ack0", o_ack0, 1);
      i_req0 = 1'b0;
      n = 0;
      do begin
         @(negedge i_clk);
         n++;
      end while (!i_tx_busy && n < 50);
      chk("rst_msg_busy_seen", n < 50, 1);
      @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
      chk("reset_mid_outputs", {o_ack0, o_ack1, o_tx_p_data, o_tx_data_valid, o_tx_par_en,
                                o_tx_par_typ, o_sched_busy, o_msg_done, o_msg_src, o_timeout_err}, 0);
      i_rst = 1'b0;
      n_ev = 0;
      repeat (15) begin
         @(negedge i_clk);
         if (o_tx_data_valid || o_msg_done) n_ev++;
      end
      chk("no_resume_after_reset", n_ev, 0);
      chk("partial_discarded", byte_q.size(), 0);
      // The last grant was 0. Reset must restore r_last so that 0 wins this tie.
      run_msg('{2'b11, 1'b0, 1'b0, 16'h0077, 16'h0088, 1'b0, 1'b1, 1'b0});
      i_req1 = 1'b0;

      // Transmitter never raises busy.
      bm_en = 0;
      byte_q.push_back('{8'hCD, 1'b0});
      i_len1 = 1'b1; i_data1 = 16'hABCD;
      i_req1 = 1'b1;
      wait_ack(n);
      chk("to_ack1", o_ack1, 1);
      i_req1 = 1'b0;
      @(negedge i_clk);
      chk("to_strobe", o_tx_data_valid, 1);
      n = 0;
      do begin
         @(negedge i_clk);
         n++;
      end while (!o_timeout_err && n < 40);
`ifdef UART_SCHED_TIMEOUT_EN
      chk("timeout_latency", n, 31);
      chk("timeout_idle", o_sched_busy, 0);
      @(negedge i_clk);
      chk("timeout_pulse_width", o_timeout_err, 0);
      chk("timeout_stays_idle", o_sched_busy, 0);
`else
      chk("no_timeout_err", n, 40);
      chk("stuck_busy", o_sched_busy, 1);
`endif
      chk("no_second_byte", byte_q.size(), 0);
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      bm_en = 1;
      repeat (3) @(negedge i_clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Sequencer and arbiter placed in front of the UART transmitter. It shares the single UART_TX between two requesters, each sending a 1- or 2-byte message. It latches the winner's payload and parity configuration, then issues bytes low-first using the transmitter's Data_Valid/busy handshake. It reports completion, and optionally reports a handshake timeout.

## Interface
- TIMEOUT, default 31: maximum cycles to wait for TX_BUSY to rise after TX_DATA_VALID; used only with UART_SCHED_TIMEOUT_EN.
- TO_W, default 5: width of the timeout counter; TIMEOUT must be < 2^TO_W.

Ports:
- CLK  in  1  single clock.
- RST  in  1  synchronous, active-high reset.
- REQ0 / REQ1  in  1  message request; held until the matching ACK.
- LEN0 / LEN1  in  1  message length: 0 = 1 byte, 1 = 2 bytes.
- DATA0 / DATA1  in  16  payload; byte0 = [7:0], byte1 = [15:8].
- ACK0 / ACK1  out  1  one-cycle pulse; payload captured on this edge.
- CFG_PAR_EN, CFG_PAR_TYP  in  1  parity configuration, sampled at grant.
- TX_P_DATA  out  8  byte to the transmitter.
- TX_DATA_VALID  out  1  one-cycle byte strobe.
- TX_PAR_EN, TX_PAR_TYP  out  1  latched parity configuration, stable for the whole message.
- TX_BUSY  in  1  busy flag from the transmitter.
- SCHED_BUSY  out  1  high in every state except IDLE.
- MSG_DONE  out  1  one-cycle pulse after the last byte's frame ends.
- MSG_SRC  out  1  requester of the current or most recent message.
- TIMEOUT_ERR  out  1  one-cycle pulse when a message is aborted.

## Operation
- All outputs are registered. Reset values: all outputs 0; last-grant register = 1, so requester 0 wins the first tie.
- State IDLE:
  - If any REQ is high, grant it. If both are high, grant the requester not granted last (round-robin).
  - On the grant edge: pulse ACKg; latch DATAg, LENg, CFG_PAR_EN and CFG_PAR_TYP; set byte index = 0; set MSG_SRC = g. Next state: ISSUE.
- State ISSUE:
  - If TX_BUSY = 0: drive TX_P_DATA = the indexed byte and TX_DATA_VALID = 1 for one cycle. Next state: WAIT_HI.
  - If TX_BUSY = 1: hold in ISSUE.
- State WAIT_HI: wait for TX_BUSY = 1, then go to WAIT_LO.
- State WAIT_LO: wait for TX_BUSY = 0.
  - If this was the last byte: pulse MSG_DONE and go to IDLE.
  - Otherwise: increment the index and go to ISSUE.
- Byte count = LEN + 1. The index is 1 bit and never wraps past the message.
- TX_PAR_EN and TX_PAR_TYP change only on a grant edge.
- Changes on CFG_PAR_* or on the non-granted requester's inputs mid-message have no effect.
- TX_P_DATA holds its last value when TX_DATA_VALID = 0.
- Dropping a REQ before it is granted withdraws the request; no ACK is issued.
- Requests that arrive while SCHED_BUSY = 1 wait. No arbitration happens outside IDLE.
- RST asserted mid-message: on the next edge, return to IDLE with reset values. The partial message is discarded, and no MSG_DONE or TIMEOUT_ERR is produced.

## Timing
- REQ sampled high at edge k in IDLE: ACK high in cycle k→k+1.
- With TX_BUSY = 0: TX_DATA_VALID high in cycle k+1→k+2.
- The transmitter raises TX_BUSY one cycle after TX_DATA_VALID. After that, the scheduler adds no idle cycles beyond WAIT_LO→ISSUE→strobe.
- Gap between bytes: two cycles from TX_BUSY falling to the next TX_DATA_VALID.
- MSG_DONE is registered on the edge that samples TX_BUSY = 0 in WAIT_LO for the last byte.
- The earliest next grant is on the edge after MSG_DONE.
- ACK and TX_DATA_VALID are never high in the same cycle.

## Configuration
- Macro: UART_SCHED_TIMEOUT_EN.
- Defined:
  - A TO_W-bit counter clears on entry to WAIT_HI and increments every cycle spent there.
  - If the count reaches TIMEOUT with TX_BUSY still 0: pulse TIMEOUT_ERR, abandon the remaining bytes, emit no MSG_DONE, and return to IDLE.
- Not defined:
  - No counter is built, and WAIT_HI waits indefinitely.
  - TIMEOUT_ERR is tied to 0.

## Test plan
- Single 1-byte message: REQ0 = 1, LEN0 = 0, DATA0 = 16'h00A5, CFG_PAR_EN = 1, CFG_PAR_TYP = 0, model busy for 10 cycles.
  - Expect one ACK0 pulse, then one TX_DATA_VALID with TX_P_DATA = 8'hA5 one cycle later.
  - Expect TX_PAR_EN = 1 throughout, and MSG_DONE with MSG_SRC = 0 after busy falls.
- 2-byte message: REQ1, LEN1 = 1, DATA1 = 16'h3C81.
  - Expect strobes with 8'h81 then 8'h3C, separated by exactly 2 cycles after busy falls.
  - Expect a single MSG_DONE and MSG_SRC = 1.
- Tie after reset: REQ0 and REQ1 high together, repeated 3 times.
  - Expect grants in the order 0, 1, 0.
  - Expect ACK and payload matching each grant.
- Parity stability: toggle CFG_PAR_TYP every cycle during a 2-byte message.
  - Expect TX_PAR_TYP to hold its grant-time value until MSG_DONE.
- Reset mid-message: assert RST in WAIT_LO of byte 0 of a 2-byte message.
  - Expect all outputs 0 on the next edge and no second byte.
  - Expect no MSG_DONE, and requester 0 winning the next tie.
- UART_SCHED_TIMEOUT_EN defined, TIMEOUT = 31, busy model stuck at 0.
  - Expect TIMEOUT_ERR 31 cycles after entry to WAIT_HI, no MSG_DONE, and SCHED_BUSY = 0 on the following cycle.
  - Without the macro, expect SCHED_BUSY to remain 1.
